pc_seq: RTL

Next-PC sequencer for the single-cycle core. Sits in front of `pc_reg` and drives its `pc_prev` and `en` inputs. It chooses the next PC (reset vector, sequential +4, branch/jump target or trap vector) and only advances when the instruction-memory handshake completes. Redirects that arrive while a fetch is outstanding are held until that fetch retires.

---
 rtl/pc_pkg.sv | 22 ++
 rtl/pc_redirect_latch.sv | 52 +++++
 rtl/pc_seq.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the next-PC sequencer.
// Holds the FSM state enum, PC width/step and default vectors.
package pc_pkg;

   localparam int PC_W = 32;

   localparam logic [PC_W-1:0] PC_STEP       = 32'd4;
   localparam logic [PC_W-1:0] RESET_VEC_DEF = 32'h0000_0000;
   localparam logic [PC_W-1:0] TRAP_VEC_DEF  = 32'h0000_0100;

   typedef enum logic [1:0] {
      BOOT,
      FETCH,
      WAIT,
      HOLD
   } pc_state_e;

   function automatic logic is_misaligned(input logic [PC_W-1:0] a);
      return a[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/pc_redirect_latch.sv
// pc_redirect_latch: remembers a trap/branch that arrives while a fetch
// is outstanding and merges it with the live request.
// Ports:
//   i_clk, i_rst_n         clock, async active-low reset
//   i_capture              latch live redirect (fetch outstanding)
//   i_clear                retire consumed the pending redirect
//   i_trap/i_br/i_target   live redirect request
//   o_trap/o_br/o_target   merged (live or pending) redirect
module pc_redirect_latch
   import pc_pkg::*;
(
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_capture,
   input  logic            i_clear,
   input  logic            i_trap,
   input  logic            i_br,
   input  logic [PC_W-1:0] i_target,
   output logic            o_trap,
   output logic            o_br,
   output logic [PC_W-1:0] o_target
);

   logic            r_trap;
   logic            r_br;
   logic [PC_W-1:0] r_target;

   // A trap never gets dropped by a later branch: the trap flag is
   // sticky and outranks the branch flag at selection time.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_trap   <= 1'b0;
         r_br     <= 1'b0;
         r_target <= '0;
      end else if (i_clear) begin
         r_trap <= 1'b0;
         r_br   <= 1'b0;
      end else if (i_capture) begin
         if (i_trap) r_trap <= 1'b1;
         if (i_br) begin
            r_br     <= 1'b1;
            r_target <= i_target;
         end
      end
   end

   // The newest branch target wins over an older pending one.
   assign o_trap   = r_trap | i_trap;
   assign o_br     = r_br | i_br;
   assign o_target = i_br ? i_target : r_target;

endmodule

// File: rtl/pc_seq.sv
// pc_seq: next-PC sequencer; drives pc_reg load and the fetch request.
// Optional misaligned-target check: define PC_ALIGN_CHECK_EN.
// Ports:
//   i_clk, i_rst_n       clock, async active-low reset
//   i_pc_cur             current PC from pc_reg
//   o_pc_next, o_pc_en   next PC and load enable for pc_reg
//   o_imem_req/i_imem_ack  instruction fetch handshake
//   i_stall              downstream hold
//   i_br_taken/i_br_target, i_trap  redirect requests
//   o_misalign           pulse on a rejected misaligned target
module pc_seq
   import pc_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_VEC = RESET_VEC_DEF,
   parameter logic [PC_W-1:0] TRAP_VEC  = TRAP_VEC_DEF
)(
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic [PC_W-1:0] i_pc_cur,
   output logic [PC_W-1:0] o_pc_next,
   output logic            o_pc_en,
   output logic            o_imem_req,
   input  logic            i_imem_ack,
   input  logic            i_stall,
   input  logic            i_br_taken,
   input  logic [PC_W-1:0] i_br_target,
   input  logic            i_trap,
   output logic            o_misalign
);

   pc_state_e       r_state;
   pc_state_e       w_state_nxt;
   logic            w_en;
   logic            w_mis;
   logic            w_retire;
   logic            w_redirect;
   logic            w_capture;
   logic            w_clear;
   logic            w_trap;
   logic            w_br;
   logic [PC_W-1:0] w_target;

   pc_redirect_latch u_latch (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_capture (w_capture),
      .i_clear   (w_clear),
      .i_trap    (i_trap),
      .i_br      (i_br_taken),
      .i_target  (i_br_target),
      .o_trap    (w_trap),
      .o_br      (w_br),
      .o_target  (w_target)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= BOOT;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      o_pc_next   = i_pc_cur + PC_STEP;
      o_imem_req  = 1'b0;
      w_en        = 1'b0;
      w_mis       = 1'b0;
      w_retire    = 1'b0;
      w_redirect  = 1'b0;
      w_capture   = 1'b0;
      w_clear     = 1'b0;
      unique case (r_state)
         BOOT: begin
            o_pc_next   = RESET_VEC;
            w_en        = 1'b1;
            w_state_nxt = FETCH;
         end
         FETCH: begin
            if (i_stall) begin
               // no fetch in flight, so a redirect can load directly
               w_redirect  = 1'b1;
               w_state_nxt = HOLD;
            end else begin
               o_imem_req = 1'b1;
               if (i_imem_ack) begin
                  w_retire = 1'b1;
               end else begin
                  w_capture   = 1'b1;
                  w_state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            o_imem_req = 1'b1;
            if (i_imem_ack) begin
               w_retire    = 1'b1;
               w_state_nxt = i_stall ? HOLD : FETCH;
            end else begin
               w_capture = 1'b1;
            end
         end
         HOLD: begin
            w_redirect = 1'b1;
            if (!i_stall) w_state_nxt = FETCH;
         end
         default: w_state_nxt = BOOT;
      endcase

      if (w_retire || (w_redirect && (w_trap || w_br))) begin
         w_en    = 1'b1;
         w_clear = w_retire;
         if (w_trap) begin
            o_pc_next = TRAP_VEC;
         end else if (w_br) begin
`ifdef PC_ALIGN_CHECK_EN
            if (is_misaligned(w_target)) begin
               o_pc_next = TRAP_VEC;
               w_mis     = 1'b1;
            end else begin
               o_pc_next = w_target;
            end
`else
            o_pc_next = w_target;
`endif
         end
      end
   end

   // BOOT is the reset state; keep pc_reg untouched while reset is held.
   assign o_pc_en    = w_en & i_rst_n;
   assign o_misalign = w_mis & i_rst_n;

endmodule
